// File: rtl/nios_periph_pkg.sv
// -----------------------------------------------------------------------------
// nios_periph_pkg
// Constants shared by the Nios II button/LED peripheral: register word
// addresses, the default ID register value and the PWM counter width.
// -----------------------------------------------------------------------------
package nios_periph_pkg;

    localparam int ADDR_W = 3;
    localparam int BUS_W  = 32;

    localparam logic [ADDR_W-1:0] REG_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] REG_EDGE     = 3'd1;
    localparam logic [ADDR_W-1:0] REG_IRQ_MASK = 3'd2;
    localparam logic [ADDR_W-1:0] REG_LED      = 3'd3;
    localparam logic [ADDR_W-1:0] REG_PWM      = 3'd4;
    localparam logic [ADDR_W-1:0] REG_ID       = 3'd5;

    localparam logic [BUS_W-1:0] DEFAULT_ID_VALUE = 32'h4E494F53;

    localparam int               PWM_W          = 8;
    localparam logic [PWM_W-1:0] PWM_DUTY_RESET = 8'hFF;
    localparam logic [PWM_W-1:0] PWM_DUTY_FULL  = 8'hFF;

endpackage

// File: rtl/nios_button_led_slave_if.sv
// -----------------------------------------------------------------------------
// nios_button_led_slave_if
// Avalon-MM slave bus bundle between the Nios II data master and the
// button/LED peripheral, plus the peripheral's level interrupt.
//   avs_address   : word address (master -> slave)
//   avs_read      : read strobe (master -> slave)
//   avs_write     : write strobe (master -> slave)
//   avs_writedata : write data (master -> slave)
//   avs_readdata  : read data, valid the cycle after avs_read (slave -> master)
//   irq           : level interrupt request, active-high (slave -> master)
// -----------------------------------------------------------------------------
interface nios_button_led_slave_if;
    import nios_periph_pkg::*;

    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [BUS_W-1:0]  avs_writedata;
    logic [BUS_W-1:0]  avs_readdata;
    logic              irq;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata,
        input  irq
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata,
        output irq
    );

endinterface

// File: rtl/nios_button_led_slave_button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Brings the raw asynchronous button pin into the clock domain, normalises
// its polarity so 1 means pressed, and accepts a new level only after it has
// been seen unchanged for DEBOUNCE_CYCLES cycles.
//   clock  : system clock
//   reset  : synchronous, active-high
//   button : raw asynchronous button pin
//   stable : debounced button state, 1 = pressed
//   rise   : one-cycle pulse in the first cycle stable reads 1
// -----------------------------------------------------------------------------
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1500000,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic stable,
    output logic rise
);

    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             sync_lvl;
    logic [CNT_W-1:0] cnt;

    // Polarity is fixed after the synchronizer so only clean levels are inverted.
    assign sync_lvl = (BTN_ACTIVE_LOW != 0) ? ~sync_p1 : sync_p1;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            stable  <= 1'b0;
            cnt     <= '0;
            rise    <= 1'b0;
        end else begin
            sync_p0 <= button;
            sync_p1 <= sync_p0;
            rise    <= 1'b0;
            if (sync_lvl == stable) begin
                // Any return to the accepted level restarts the qualification window.
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync_lvl;
                rise   <= sync_lvl;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nios_button_led_slave.sv
// -----------------------------------------------------------------------------
// nios_button_led_slave
// Register-mapped button and LED peripheral for the Nios II data master.
// Button: synchronised and debounced, presses latched in EDGE (write 1 to
// clear) and optionally raised as a level interrupt. LEDs: a register gated
// by an 8-bit free-running PWM for brightness.
//   clock  : system clock
//   reset  : synchronous, active-high
//   avs    : Avalon-MM slave bus and irq (read latency 1, no waitrequest)
//   button : raw asynchronous button pin
//   leds   : registered LED drive
// Word map: 0 DATA(R) 1 EDGE(R/W1C) 2 IRQ_MASK 3 LED 4 PWM 5 ID(R) 6-7 zero.
// -----------------------------------------------------------------------------
module nios_button_led_slave
    import nios_periph_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 1500000,
    parameter int          LED_W           = 4,
    parameter int          BTN_ACTIVE_LOW  = 1,
    parameter logic [31:0] ID_VALUE        = DEFAULT_ID_VALUE
) (
    input  logic                    clock,
    input  logic                    reset,
    nios_button_led_slave_if.slave  avs,
    input  logic                    button,
    output logic [LED_W-1:0]        leds
);

    logic             btn_stable;
    logic             btn_rise;

    logic             edge_q;
    logic             mask_q;
    logic [LED_W-1:0] led_q;
    logic [PWM_W-1:0] duty_q;
    logic [PWM_W-1:0] pwm_cnt;
    logic             pwm_on;
    logic             irq_q;
    logic [BUS_W-1:0] rdata_mux;
    logic [BUS_W-1:0] rdata_q;

    logic             wr_edge;
    logic             wr_mask;
    logic             wr_led;
    logic             wr_pwm;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_deb (
        .clock  (clock),
        .reset  (reset),
        .button (button),
        .stable (btn_stable),
        .rise   (btn_rise)
    );

    assign wr_edge = avs.avs_write && (avs.avs_address == REG_EDGE);
    assign wr_mask = avs.avs_write && (avs.avs_address == REG_IRQ_MASK);
    assign wr_led  = avs.avs_write && (avs.avs_address == REG_LED);
    assign wr_pwm  = avs.avs_write && (avs.avs_address == REG_PWM);

    // Full duty is forced on; otherwise cnt < 255 would leave one dark cycle per period.
    assign pwm_on = (pwm_cnt < duty_q) || (duty_q == PWM_DUTY_FULL);

    // Read mux works on current register values, so a simultaneous write
    // is not yet visible and the pre-write value is returned.
    always_comb begin
        rdata_mux = '0;
        unique case (avs.avs_address)
            REG_DATA:     rdata_mux = BUS_W'(btn_stable);
            REG_EDGE:     rdata_mux = BUS_W'(edge_q);
            REG_IRQ_MASK: rdata_mux = BUS_W'(mask_q);
            REG_LED:      rdata_mux = BUS_W'(led_q);
            REG_PWM:      rdata_mux = BUS_W'(duty_q);
            REG_ID:       rdata_mux = ID_VALUE;
            default:      rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            edge_q  <= 1'b0;
            mask_q  <= 1'b0;
            led_q   <= '0;
            duty_q  <= PWM_DUTY_RESET;
            pwm_cnt <= '0;
            irq_q   <= 1'b0;
            leds    <= '0;
            rdata_q <= '0;
        end else begin
            // A press arriving with a clear in the same cycle must not be lost.
            if (btn_rise) begin
                edge_q <= 1'b1;
            end else if (wr_edge && avs.avs_writedata[0]) begin
                edge_q <= 1'b0;
            end

            if (wr_mask) begin
                mask_q <= avs.avs_writedata[0];
            end
            if (wr_led) begin
                led_q <= avs.avs_writedata[LED_W-1:0];
            end
            if (wr_pwm) begin
                duty_q <= avs.avs_writedata[PWM_W-1:0];
            end

            irq_q   <= edge_q & mask_q;
            pwm_cnt <= pwm_cnt + 1'b1;
            leds    <= led_q & {LED_W{pwm_on}};

            if (avs.avs_read) begin
                rdata_q <= rdata_mux;
            end
        end
    end

    assign avs.avs_readdata = rdata_q;
    assign avs.irq          = irq_q;

endmodule

// File: tb/tb_nios_button_led_slave.sv
module tb_nios_button_led_slave;
    import nios_periph_pkg::*;

    localparam int DEB   = 16;
    localparam int LED_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             button;
    logic [LED_W-1:0] leds;

    int checks = 0;
    int errors = 0;

    nios_button_led_slave_if bus ();

    nios_button_led_slave #(
        .DEBOUNCE_CYCLES (DEB),
        .LED_W           (LED_W),
        .BTN_ACTIVE_LOW  (1),
        .ID_VALUE        (32'h4E494F53)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .avs    (bus.slave),
        .button (button),
        .leds   (leds)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        bus.avs_address   = addr;
        bus.avs_writedata = data;
        bus.avs_write     = 1'b1;
        tick();
        bus.avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
        bus.avs_address = addr;
        bus.avs_read    = 1'b1;
        tick();
        bus.avs_read    = 1'b0;
        data            = bus.avs_readdata;
    endtask

    task automatic count_on(output int on_cnt, output int bad_cnt);
        on_cnt  = 0;
        bad_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (leds == 4'hF) on_cnt++;
            else if (leds != 4'h0) bad_cnt++;
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          on_cnt;
        int          bad_cnt;

        bus.avs_address   = '0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        button            = 1'b1;
        reset             = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_readdata", bus.avs_readdata, 32'h0);
        check("rst_irq", 32'(bus.irq), 32'h0);
        check("rst_leds", 32'(leds), 32'h0);
        reset = 1'b0;
        repeat (5) tick();
        bus_read(3'd5, rd); check("rst_id", rd, 32'h4E494F53);
        bus_read(3'd4, rd); check("rst_pwm", rd, 32'hFF);
        bus_read(3'd0, rd); check("rst_data", rd, 32'h0);
        bus_read(3'd1, rd); check("rst_edge", rd, 32'h0);
        bus_read(3'd2, rd); check("rst_mask", rd, 32'h0);
        bus_read(3'd3, rd); check("rst_led", rd, 32'h0);

        // Glitch of 10 cycles is rejected
        button = 1'b0;
        repeat (10) tick();
        button = 1'b1;
        repeat (30) tick();
        bus_read(3'd0, rd); check("glitch_data", rd, 32'h0);
        bus_read(3'd1, rd); check("glitch_edge", rd, 32'h0);

        // Press: stable rises on the 18th edge after the pin falls, so a read
        // sampled on edge 18 still returns 0 and one on edge 19 returns 1.
        bus.avs_address = 3'd0;
        bus.avs_read    = 1'b1;
        button          = 1'b0;
        for (int n = 1; n <= 19; n++) begin
            tick();
            if (n == 18) check("press_data_e18", bus.avs_readdata, 32'h0);
            if (n == 19) check("press_data_e19", bus.avs_readdata, 32'h1);
        end
        bus.avs_read = 1'b0;
        tick();
        bus_read(3'd1, rd); check("press_edge", rd, 32'h1);

        // IRQ
        check("irq_masked", 32'(bus.irq), 32'h0);
        bus_write(3'd2, 32'h1);
        check("irq_mask_same", 32'(bus.irq), 32'h0);
        tick();
        check("irq_set", 32'(bus.irq), 32'h1);
        bus_write(3'd1, 32'h1);
        tick();
        check("irq_cleared", 32'(bus.irq), 32'h0);
        bus_read(3'd1, rd); check("edge_w1c", rd, 32'h0);
        button = 1'b1;
        repeat (25) tick();
        check("irq_release", 32'(bus.irq), 32'h0);
        bus_read(3'd0, rd); check("release_data", rd, 32'h0);
        button = 1'b0;
        repeat (25) tick();
        check("irq_repress", 32'(bus.irq), 32'h1);
        bus_write(3'd1, 32'h0);
        bus_read(3'd1, rd); check("edge_write0", rd, 32'h1);

        // Set/clear collision: W1C sampled on the same edge that sets EDGE
        bus_write(3'd1, 32'h1);
        bus_read(3'd1, rd); check("edge_pre_coll", rd, 32'h0);
        button = 1'b1;
        repeat (25) tick();
        button = 1'b0;
        repeat (18) tick();
        bus_write(3'd1, 32'h1);
        bus_read(3'd1, rd); check("edge_collision", rd, 32'h1);
        bus_write(3'd2, 32'h0);

        // PWM
        bus_write(3'd3, 32'hF);
        bus_write(3'd4, 32'd64);
        repeat (3) tick();
        count_on(on_cnt, bad_cnt);
        check("pwm64_on", 32'(on_cnt), 32'd64);
        check("pwm64_bad", 32'(bad_cnt), 32'd0);
        bus_write(3'd4, 32'd0);
        repeat (3) tick();
        count_on(on_cnt, bad_cnt);
        check("pwm0_on", 32'(on_cnt), 32'd0);
        bus_write(3'd4, 32'd255);
        repeat (3) tick();
        count_on(on_cnt, bad_cnt);
        check("pwm255_on", 32'(on_cnt), 32'd256);

        // Bus misc
        bus_write(3'd6, 32'hDEADBEEF);
        bus_read(3'd6, rd); check("addr6", rd, 32'h0);
        bus_read(3'd7, rd); check("addr7", rd, 32'h0);
        bus_write(3'd3, 32'h3);
        bus.avs_address   = 3'd3;
        bus.avs_writedata = 32'h5;
        bus.avs_read      = 1'b1;
        bus.avs_write     = 1'b1;
        tick();
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        check("rw_old", bus.avs_readdata, 32'h3);
        bus_read(3'd3, rd); check("rw_new", rd, 32'h5);
        repeat (3) tick();
        check("rd_hold", bus.avs_readdata, 32'h5);
        bus_read(3'd5, rd); check("id", rd, 32'h4E494F53);

        // Reset during a read
        bus.avs_address = 3'd5;
        bus.avs_read    = 1'b1;
        reset           = 1'b1;
        tick();
        check("rst_mid_read", bus.avs_readdata, 32'h0);
        check("rst_mid_leds", 32'(leds), 32'h0);
        bus.avs_read = 1'b0;
        reset        = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
